// File: rtl/ami_if.sv
// ---------------------------------------------------------------------------
// ami_if : AXI4 bus bundle between the ami master and an AXI slave.
//   master modport : drives AW/W/AR channels and BREADY/RREADY,
//                    observes AWREADY/WREADY/ARREADY and the B/R channels.
//   slave  modport : the mirror image, for slave models or real slaves.
// Parameters: DW data width, AW address width, IW ID width, LW AxLEN width,
//             SW AxSIZE width. WSTRB width is DW/8.
// ---------------------------------------------------------------------------
interface ami_if #(
  parameter int DW = 128,
  parameter int AW = 40,
  parameter int IW = 8,
  parameter int LW = 8,
  parameter int SW = 3
);
  // write address channel
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [LW-1:0]   awlen;
  logic [SW-1:0]   awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  // write data channel
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  // write response channel
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  // read address channel
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [LW-1:0]   arlen;
  logic [SW-1:0]   arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  // read data channel
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ami.sv
// ---------------------------------------------------------------------------
// ami : AXI4 master interface.
//   Converts user burst commands into AXI4 INCR bursts. Write and read paths
//   are independent FSMs, each with one outstanding transaction. Beat data
//   passes straight through between the user ports and the AXI bus (no
//   buffering), so the user handshakes are the AXI handshakes while a burst
//   is in its data phase.
// Ports:
//   ACLK, ARESETn             clock, asynchronous active-low reset
//   axi (ami_if.master)       AXI4 AW/W/B/AR/R channels
//   usr_wcmd_*                write command (addr/len/size) handshake
//   usr_wdata/wstrb/wvalid/wready  write beat stream
//   usr_wdone, usr_wresp      1-cycle completion pulse, last BRESP (held)
//   usr_rcmd_*                read command (addr/len/size) handshake
//   usr_rdata/rresp/rlast/rvalid/rready  read beat stream
//   usr_rdone, usr_rerr       1-cycle completion pulse, sticky RLAST error
// ---------------------------------------------------------------------------
module ami #(
  parameter int                AXI_DW     = 128,
  parameter int                AXI_AW     = 40,
  parameter int                AXI_IW     = 8,
  parameter int                AXI_LW     = 8,
  parameter int                AXI_SW     = 3,
  parameter logic [AXI_IW-1:0] AMI_ID     = '0,
  parameter int                AXI_WSTRBW = AXI_DW / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  ami_if.master                 axi,
  // write command / beat stream
  input  logic                  usr_wcmd_valid,
  output logic                  usr_wcmd_ready,
  input  logic [AXI_AW-1:0]     usr_wcmd_addr,
  input  logic [AXI_LW-1:0]     usr_wcmd_len,
  input  logic [AXI_SW-1:0]     usr_wcmd_size,
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_WSTRBW-1:0] usr_wstrb,
  input  logic                  usr_wvalid,
  output logic                  usr_wready,
  output logic                  usr_wdone,
  output logic [1:0]            usr_wresp,
  // read command / beat stream
  input  logic                  usr_rcmd_valid,
  output logic                  usr_rcmd_ready,
  input  logic [AXI_AW-1:0]     usr_rcmd_addr,
  input  logic [AXI_LW-1:0]     usr_rcmd_len,
  input  logic [AXI_SW-1:0]     usr_rcmd_size,
  output logic [AXI_DW-1:0]     usr_rdata,
  output logic [1:0]            usr_rresp,
  output logic                  usr_rlast,
  output logic                  usr_rvalid,
  input  logic                  usr_rready,
  output logic                  usr_rdone,
  output logic                  usr_rerr
);

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [1:0]        wstate;
  logic [1:0]        rstate;
  logic [AXI_AW-1:0] aw_addr;
  logic [AXI_LW-1:0] aw_len;
  logic [AXI_SW-1:0] aw_size;
  logic [AXI_AW-1:0] ar_addr;
  logic [AXI_LW-1:0] ar_len;
  logic [AXI_SW-1:0] ar_size;
  logic [AXI_LW-1:0] wcnt;
  logic [AXI_LW-1:0] rcnt;

  logic w_beat;
  logic w_last_beat;
  logic r_beat;
  logic r_last_beat;

  // BID/RID are not used: only one transaction per direction is in flight.
  logic unused_ids;
  assign unused_ids = ^{axi.bid, axi.rid};

  // ---------------- write path ----------------
  assign usr_wcmd_ready = (wstate == W_IDLE);

  assign axi.awid    = AMI_ID;
  assign axi.awaddr  = aw_addr;
  assign axi.awlen   = aw_len;
  assign axi.awsize  = aw_size;
  assign axi.awburst = BURST_INCR;
  assign axi.awvalid = (wstate == W_ADDR);

  // W is gated by state so no beat can leave before the AW handshake.
  assign axi.wdata   = usr_wdata;
  assign axi.wstrb   = usr_wstrb;
  assign axi.wvalid  = (wstate == W_DATA) & usr_wvalid;
  assign usr_wready  = (wstate == W_DATA) & axi.wready;
  assign w_last_beat = (wcnt == aw_len);
  assign axi.wlast   = (wstate == W_DATA) & w_last_beat;
  assign w_beat      = axi.wvalid & axi.wready;

  assign axi.bready  = (wstate == W_RESP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate    <= W_IDLE;
      wcnt      <= '0;
      aw_addr   <= '0;
      aw_len    <= '0;
      aw_size   <= '0;
      usr_wdone <= 1'b0;
      usr_wresp <= 2'b00;
    end else begin
      usr_wdone <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (usr_wcmd_valid) begin
            aw_addr <= usr_wcmd_addr;
            aw_len  <= usr_wcmd_len;
            aw_size <= usr_wcmd_size;
            wstate  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (axi.awready) begin
            wcnt   <= '0;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          // The counter stops at aw_len, so len=255 never wraps.
          if (w_beat) begin
            if (w_last_beat) wstate <= W_RESP;
            else             wcnt   <= wcnt + 1'b1;
          end
        end
        W_RESP: begin
          if (axi.bvalid) begin
            usr_wdone <= 1'b1;
            usr_wresp <= axi.bresp;
            wstate    <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  assign usr_rcmd_ready = (rstate == R_IDLE);

  assign axi.arid    = AMI_ID;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = ar_len;
  assign axi.arsize  = ar_size;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = (rstate == R_ADDR);

  assign usr_rdata   = axi.rdata;
  assign usr_rresp   = axi.rresp;
  assign usr_rvalid  = (rstate == R_DATA) & axi.rvalid;
  assign axi.rready  = (rstate == R_DATA) & usr_rready;
  assign r_last_beat = (rcnt == ar_len);
  assign usr_rlast   = (rstate == R_DATA) & r_last_beat;
  assign r_beat      = axi.rvalid & axi.rready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate    <= R_IDLE;
      rcnt      <= '0;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_size   <= '0;
      usr_rdone <= 1'b0;
      usr_rerr  <= 1'b0;
    end else begin
      usr_rdone <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (usr_rcmd_valid) begin
            ar_addr  <= usr_rcmd_addr;
            ar_len   <= usr_rcmd_len;
            ar_size  <= usr_rcmd_size;
            usr_rerr <= 1'b0;
            rstate   <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (axi.arready) begin
            rcnt   <= '0;
            rstate <= R_DATA;
          end
        end
        R_DATA: begin
          // The burst length comes from our own count; RLAST is only
          // cross-checked and never ends the burst early or late.
          if (r_beat) begin
            if (axi.rlast != r_last_beat) usr_rerr <= 1'b1;
            if (r_last_beat) begin
              usr_rdone <= 1'b1;
              rstate    <= R_IDLE;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ami.sv
module tb_ami;
  localparam int DW  = 128;
  localparam int AW  = 40;
  localparam int IW  = 8;
  localparam int LW  = 8;
  localparam int SW  = 3;
  localparam int SBW = DW / 8;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b1;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int nassert = 0;
  int nfail   = 0;

  ami_if #(.DW(DW), .AW(AW), .IW(IW), .LW(LW), .SW(SW)) axi ();

  logic           usr_wcmd_valid, usr_wcmd_ready;
  logic [AW-1:0]  usr_wcmd_addr;
  logic [LW-1:0]  usr_wcmd_len;
  logic [SW-1:0]  usr_wcmd_size;
  logic [DW-1:0]  usr_wdata;
  logic [SBW-1:0] usr_wstrb;
  logic           usr_wvalid, usr_wready, usr_wdone;
  logic [1:0]     usr_wresp;
  logic           usr_rcmd_valid, usr_rcmd_ready;
  logic [AW-1:0]  usr_rcmd_addr;
  logic [LW-1:0]  usr_rcmd_len;
  logic [SW-1:0]  usr_rcmd_size;
  logic [DW-1:0]  usr_rdata;
  logic [1:0]     usr_rresp;
  logic           usr_rlast, usr_rvalid, usr_rready, usr_rdone, usr_rerr;

  ami #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
        .AMI_ID(8'h00)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
    .usr_wcmd_valid(usr_wcmd_valid), .usr_wcmd_ready(usr_wcmd_ready),
    .usr_wcmd_addr(usr_wcmd_addr), .usr_wcmd_len(usr_wcmd_len),
    .usr_wcmd_size(usr_wcmd_size), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready), .usr_wdone(usr_wdone),
    .usr_wresp(usr_wresp),
    .usr_rcmd_valid(usr_rcmd_valid), .usr_rcmd_ready(usr_rcmd_ready),
    .usr_rcmd_addr(usr_rcmd_addr), .usr_rcmd_len(usr_rcmd_len),
    .usr_rcmd_size(usr_rcmd_size), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp),
    .usr_rlast(usr_rlast), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .usr_rdone(usr_rdone), .usr_rerr(usr_rerr)
  );

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic init_inputs();
    usr_wcmd_valid = 0; usr_wcmd_addr = '0; usr_wcmd_len = '0; usr_wcmd_size = '0;
    usr_wdata = '0; usr_wstrb = '0; usr_wvalid = 0;
    usr_rcmd_valid = 0; usr_rcmd_addr = '0; usr_rcmd_len = '0; usr_rcmd_size = '0;
    usr_rready = 0;
    axi.awready = 0; axi.wready = 0; axi.bid = '0; axi.bresp = '0; axi.bvalid = 0;
    axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.rvalid = 0;
  endtask

  // Full write transaction: user source + AXI slave model, checked beat by beat
  // against a queue of expected beats built up front.
  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input logic [SW-1:0] size, input int aw_stall, input bit rnd,
                          input logic [1:0] bresp, output int acc_cyc);
    logic [DW-1:0]  exp_d[$];
    logic [SBW-1:0] exp_s[$];
    logic           exp_last;
    int i, awcyc, guard;
    bit hs;
    for (int k = 0; k <= int'(len); k++) begin
      exp_d.push_back(rnd_data());
      exp_s.push_back(SBW'($urandom()));
    end
    @(posedge ACLK); #1;
    usr_wcmd_valid = 1; usr_wcmd_addr = addr; usr_wcmd_len = len; usr_wcmd_size = size;
    usr_wvalid = 1; usr_wdata = exp_d[0]; usr_wstrb = exp_s[0];
    #1;
    guard = 0;
    while (!usr_wcmd_ready && guard < 100) begin @(posedge ACLK); #2; guard++; end
    nassert++;
    if (usr_wcmd_ready !== 1'b1) begin nfail++; $display("FAIL wcmd_ready: got %b want 1", usr_wcmd_ready); end
    @(posedge ACLK); #1;
    acc_cyc = cyc;
    usr_wcmd_valid = 0;
    // AW phase: usr_wvalid stays high to prove W is held off until AW completes
    awcyc = 0; hs = 0; guard = 0;
    while (!hs && guard < 200) begin
      axi.awready = rnd ? ($urandom_range(0, 3) == 0) : (awcyc >= aw_stall);
      #1;
      nassert++;
      if (axi.wvalid !== 1'b0) begin nfail++; $display("FAIL w_before_aw: wvalid=%b want 0", axi.wvalid); end
      if (axi.awvalid) begin
        awcyc++;
        nassert++;
        if ({axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid} !== {addr, len, size, 2'b01, 8'h00}) begin
          nfail++;
          $display("FAIL aw_payload: got %h/%h/%h/%h/%h want %h/%h/%h/1/0",
                   axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid, addr, len, size);
        end
      end
      hs = axi.awvalid && axi.awready;
      guard++;
      @(posedge ACLK); #1;
    end
    axi.awready = 0;
    nassert++;
    if (!hs) begin nfail++; $display("FAIL aw_timeout: awvalid cycles %0d, no handshake", awcyc); end
    if (!rnd) begin
      nassert++;
      if (awcyc != aw_stall + 1) begin nfail++; $display("FAIL aw_valid_cycles: got %0d want %0d", awcyc, aw_stall + 1); end
    end
    // W phase
    i = 0; guard = 0;
    while (i <= int'(len) && guard < 5000) begin
      usr_wvalid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      usr_wdata   = exp_d[i];
      usr_wstrb   = exp_s[i];
      axi.wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      nassert++;
      if ({axi.wvalid, usr_wready} !== {usr_wvalid, axi.wready}) begin
        nfail++;
        $display("FAIL w_handshake: wvalid/usr_wready %b%b want %b%b", axi.wvalid, usr_wready, usr_wvalid, axi.wready);
      end
      if (axi.wvalid && axi.wready) begin
        exp_last = (i == int'(len));
        nassert++;
        if ({axi.wdata, axi.wstrb, axi.wlast} !== {exp_d[i], exp_s[i], exp_last}) begin
          nfail++;
          $display("FAIL w_beat%0d: got %h/%h/%b want %h/%h/%b", i, axi.wdata, axi.wstrb, axi.wlast,
                   exp_d[i], exp_s[i], exp_last);
        end
        i++;
      end
      guard++;
      @(posedge ACLK); #1;
    end
    usr_wvalid = 0; axi.wready = 0;
    nassert++;
    if (i <= int'(len)) begin nfail++; $display("FAIL w_timeout: beats %0d want %0d", i, int'(len) + 1); end
    // B phase
    hs = 0; guard = 0;
    while (!hs && guard < 100) begin
      axi.bvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bresp  = bresp;
      axi.bid    = IW'($urandom());
      #1;
      nassert++;
      if (usr_wdone !== 1'b0) begin nfail++; $display("FAIL wdone_early: got %b want 0", usr_wdone); end
      if (axi.bvalid) begin
        nassert++;
        if (axi.bready !== 1'b1) begin nfail++; $display("FAIL bready: got %b want 1", axi.bready); end
      end
      hs = axi.bvalid && axi.bready;
      guard++;
      @(posedge ACLK); #1;
    end
    axi.bvalid = 0;
    #1;
    nassert++;
    if ({usr_wdone, usr_wresp, usr_wcmd_ready} !== {1'b1, bresp, 1'b1}) begin
      nfail++;
      $display("FAIL wdone_pulse: done/resp/ready %b/%0d/%b want 1/%0d/1", usr_wdone, usr_wresp, usr_wcmd_ready, bresp);
    end
    @(posedge ACLK); #2;
    nassert++;
    if ({usr_wdone, usr_wresp} !== {1'b0, bresp}) begin
      nfail++;
      $display("FAIL wdone_one_cycle: done/resp %b/%0d want 0/%0d", usr_wdone, usr_wresp, bresp);
    end
  endtask

  // Full read transaction. bad_last < 0: slave RLAST is correct; otherwise the
  // slave asserts RLAST only on beat bad_last.
  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input logic [SW-1:0] size, input int bad_last, input bit rnd,
                         output int acc_cyc);
    logic [DW-1:0] exp_d[$];
    logic [1:0]    exp_r[$];
    logic          slv_last[$];
    logic          exp_last, exp_err;
    int i, guard;
    bit hs;
    exp_err = 0;
    for (int k = 0; k <= int'(len); k++) begin
      exp_d.push_back(rnd_data());
      exp_r.push_back(2'($urandom()));
      slv_last.push_back((bad_last < 0) ? (k == int'(len)) : (k == bad_last));
      if (slv_last[k] != (k == int'(len))) exp_err = 1;
    end
    @(posedge ACLK); #1;
    usr_rcmd_valid = 1; usr_rcmd_addr = addr; usr_rcmd_len = len; usr_rcmd_size = size;
    #1;
    guard = 0;
    while (!usr_rcmd_ready && guard < 100) begin @(posedge ACLK); #2; guard++; end
    nassert++;
    if (usr_rcmd_ready !== 1'b1) begin nfail++; $display("FAIL rcmd_ready: got %b want 1", usr_rcmd_ready); end
    @(posedge ACLK); #1;
    acc_cyc = cyc;
    usr_rcmd_valid = 0;
    nassert++;
    if (usr_rerr !== 1'b0) begin nfail++; $display("FAIL rerr_clear: got %b want 0", usr_rerr); end
    // AR phase
    hs = 0; guard = 0;
    while (!hs && guard < 200) begin
      axi.arready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      if (axi.arvalid) begin
        nassert++;
        if ({axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid} !== {addr, len, size, 2'b01, 8'h00}) begin
          nfail++;
          $display("FAIL ar_payload: got %h/%h/%h/%h/%h want %h/%h/%h/1/0",
                   axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, addr, len, size);
        end
      end
      hs = axi.arvalid && axi.arready;
      guard++;
      @(posedge ACLK); #1;
    end
    axi.arready = 0;
    nassert++;
    if (!hs) begin nfail++; $display("FAIL ar_timeout: no handshake in %0d cycles", guard); end
    // R phase
    i = 0; guard = 0;
    while (i <= int'(len) && guard < 5000) begin
      axi.rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi.rdata  = exp_d[i];
      axi.rresp  = exp_r[i];
      axi.rlast  = slv_last[i];
      axi.rid    = IW'($urandom());
      usr_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      nassert++;
      if ({usr_rvalid, axi.rready, usr_rdone} !== {axi.rvalid, usr_rready, 1'b0}) begin
        nfail++;
        $display("FAIL r_handshake: usr_rvalid/rready/rdone %b%b%b want %b%b0", usr_rvalid, axi.rready,
                 usr_rdone, axi.rvalid, usr_rready);
      end
      if (axi.rvalid && axi.rready) begin
        exp_last = (i == int'(len));
        nassert++;
        if ({usr_rdata, usr_rresp, usr_rlast} !== {exp_d[i], exp_r[i], exp_last}) begin
          nfail++;
          $display("FAIL r_beat%0d: got %h/%0d/%b want %h/%0d/%b", i, usr_rdata, usr_rresp, usr_rlast,
                   exp_d[i], exp_r[i], exp_last);
        end
        i++;
      end
      guard++;
      @(posedge ACLK); #1;
    end
    axi.rvalid = 0; axi.rlast = 0; usr_rready = 0;
    nassert++;
    if (i <= int'(len)) begin nfail++; $display("FAIL r_timeout: beats %0d want %0d", i, int'(len) + 1); end
    #1;
    nassert++;
    if ({usr_rdone, usr_rerr, usr_rcmd_ready} !== {1'b1, exp_err, 1'b1}) begin
      nfail++;
      $display("FAIL rdone_pulse: done/err/ready %b/%b/%b want 1/%b/1", usr_rdone, usr_rerr, usr_rcmd_ready, exp_err);
    end
    @(posedge ACLK); #2;
    nassert++;
    if ({usr_rdone, usr_rerr} !== {1'b0, exp_err}) begin
      nfail++;
      $display("FAIL rdone_one_cycle: done/err %b/%b want 0/%b", usr_rdone, usr_rerr, exp_err);
    end
  endtask

  task automatic test_reset();
    init_inputs();
    #2 ARESETn = 0;
    repeat (3) @(posedge ACLK);
    #1;
    nassert++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, usr_wdone, usr_rdone, usr_rerr} !== 8'h00) begin
      nfail++;
      $display("FAIL reset_ctrl: got %b want 00000000", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
               axi.rready, usr_wdone, usr_rdone, usr_rerr});
    end
    nassert++;
    if ({axi.awaddr, axi.awlen, axi.awsize, axi.araddr, axi.arlen, axi.arsize, axi.awid, axi.arid} !== '0) begin
      nfail++;
      $display("FAIL reset_payload: aw %h/%h/%h ar %h/%h/%h want 0", axi.awaddr, axi.awlen, axi.awsize,
               axi.araddr, axi.arlen, axi.arsize);
    end
    ARESETn = 1;
    @(posedge ACLK); #1;
    nassert++;
    if ({usr_wcmd_ready, usr_rcmd_ready, axi.awburst, axi.arburst} !== 6'b110101) begin
      nfail++;
      $display("FAIL reset_ready: got %b want 110101", {usr_wcmd_ready, usr_rcmd_ready, axi.awburst, axi.arburst});
    end
  endtask

  task automatic test_write_basic();
    int a;
    do_write(40'h100, 8'd3, 3'd4, 0, 1'b0, 2'd0, a);
  endtask

  task automatic test_aw_stall();
    int a;
    do_write(40'h2340, 8'd1, 3'd4, 5, 1'b0, 2'd1, a);
  endtask

  task automatic test_read_len();
    int a;
    do_read(40'h400, 8'd0, 3'd4, -1, 1'b0, a);
    do_read(40'h1000, 8'd255, 3'd4, -1, 1'b0, a);
  endtask

  task automatic test_read_bad_last();
    int a;
    do_read(40'h80, 8'd3, 3'd4, 2, 1'b0, a);
    do_read(40'h90, 8'd1, 3'd4, -1, 1'b0, a);
  endtask

  task automatic test_concurrent();
    int wa, ra;
    for (int n = 0; n < 4; n++) begin
      fork
        do_write(AW'({$urandom(), $urandom()}), LW'($urandom_range(0, 15)), 3'd4, 0, 1'b1, 2'd2, wa);
        do_read(AW'({$urandom(), $urandom()}), LW'($urandom_range(0, 15)), 3'd4, -1, 1'b1, ra);
      join
      nassert++;
      if (wa != ra) begin nfail++; $display("FAIL same_cycle_accept: write cyc %0d read cyc %0d", wa, ra); end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    for (int n = 0; n < 3; n++)
      do_write(AW'($urandom()), LW'($urandom_range(0, 7)), 3'($urandom_range(0, 4)), 0, 1'b1,
               2'($urandom()), a);
  endtask

  task automatic test_reset_mid_burst();
    int beats, guard, a;
    @(posedge ACLK); #1;
    usr_wcmd_valid = 1; usr_wcmd_addr = 40'h200; usr_wcmd_len = 8'd3; usr_wcmd_size = 3'd4;
    @(posedge ACLK); #1;
    usr_wcmd_valid = 0;
    axi.awready = 1;
    @(posedge ACLK); #1;
    axi.awready = 0;
    beats = 0; guard = 0;
    while (beats < 2 && guard < 50) begin
      usr_wvalid = 1; usr_wdata = rnd_data(); usr_wstrb = '1; axi.wready = 1;
      #1;
      if (axi.wvalid && axi.wready) beats++;
      guard++;
      @(posedge ACLK); #1;
    end
    nassert++;
    if (beats != 2) begin nfail++; $display("FAIL rst_prep_beats: got %0d want 2", beats); end
    // beat 3 is being offered when reset hits
    #1;
    ARESETn = 0;
    #1;
    nassert++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, usr_wdone, usr_wready} !== 7'b0) begin
      nfail++;
      $display("FAIL rst_mid_valids: got %b want 0000000", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
               axi.rready, usr_wdone, usr_wready});
    end
    usr_wvalid = 0; axi.wready = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    for (int n = 0; n < 5; n++) begin
      axi.bvalid = 1; axi.bresp = 2'd3;
      #1;
      nassert++;
      if ({usr_wdone, usr_wcmd_ready, axi.bready} !== 3'b010) begin
        nfail++;
        $display("FAIL rst_after: done/ready/bready %b want 010", {usr_wdone, usr_wcmd_ready, axi.bready});
      end
      @(posedge ACLK); #1;
    end
    axi.bvalid = 0; axi.bresp = 0;
    do_write(40'h300, 8'd3, 3'd4, 0, 1'b0, 2'd0, a);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_aw_stall();
    test_read_len();
    test_read_bad_last();
    test_concurrent();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
